div_ctrl: RTL and testbench

//  Iterative multi-cycle divider with a sequencing FSM for DIV/DIVU in the EX stage.
//  - Accepts one divide request, stalls the pipeline while iterating, then delivers

---
 rtl/div_ctrl.sv | 132 +++++++++++++
 tb/tb_div_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Iterative restoring divider for DIV/DIVU in EX: stalls the pipe while iterating,
// then presents quotient (LO) / remainder (HI) with a one-cycle HI/LO write strobe.
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             stall,
  output logic             ready,
  output logic             hilo_we,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;
  logic [WIDTH-1:0] r_result_hi;
  logic [WIDTH-1:0] r_result_lo;

  logic             w_accept;
  logic             w_last;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  assign w_accept = (r_state == S_IDLE) && start && !annul;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Operand magnitudes; |MIN| is representable as an unsigned WIDTH-bit value
  assign w_a_neg = signed_div & opa[WIDTH-1];
  assign w_b_neg = signed_div & opb[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~opa + WIDTH'(1)) : opa;
  assign w_b_mag = w_b_neg ? (~opb + WIDTH'(1)) : opb;

  // One restoring step: the WIDTH+1 bit difference's MSB is the borrow
  assign w_trial  = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
  assign w_fits   = ~w_trial[WIDTH];
  assign w_rem_nx = w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_fits};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (opb == '0) ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (annul)       w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall       = w_accept || (r_state == S_BUSY);
    ready       = (r_state == S_DONE);
    hilo_we     = (r_state == S_DONE) && !annul;
    div_by_zero = (r_state == S_DONE) && r_dbz;
  end

  // Datapath; results are loaded only on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz       <= 1'b0;
      r_result_hi <= '0;
      r_result_lo <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_rem   <= '0;
        r_quo   <= w_a_mag;
        r_dvs   <= w_b_mag;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_dbz   <= (opb == '0);
        if (opb == '0) begin
          r_result_lo <= '1;
          r_result_hi <= opa;
        end
      end
    end else if ((r_state == S_BUSY) && !annul) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_result_lo <= r_neg_q ? (~w_quo_nx + WIDTH'(1)) : w_quo_nx;
        r_result_hi <= r_neg_r ? (~w_rem_nx + WIDTH'(1)) : w_rem_nx;
      end
    end
  end

  assign result_hi = r_result_hi;
  assign result_lo = r_result_lo;

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized self-checking bench for div_ctrl against an arithmetic reference model.
module tb_div_ctrl;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic         signed_div;
  logic         annul;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         stall;
  logic         ready;
  logic         hilo_we;
  logic         div_by_zero;
  logic [W-1:0] result_hi;
  logic [W-1:0] result_lo;

  int n_checks;
  int n_fail;
  logic [W-1:0] last_lo;
  logic [W-1:0] last_hi;

  div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
    .opa(opa), .opb(opb), .stall(stall), .ready(ready), .hilo_we(hilo_we),
    .div_by_zero(div_by_zero), .result_hi(result_hi), .result_lo(result_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: DIVU via unsigned arithmetic, DIV via signed truncating arithmetic
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!sg) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end
  endfunction

  // Issue one divide and follow it to DONE, checking latency, stall span and results
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sg);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int lat;
    int stalls;
    int early_we;
    model(a, b, sg, eq, er);
    start = 1'b1; opa = a; opb = b; signed_div = sg;
    #1;
    stalls = stall ? 1 : 0;
    early_we = 0;
    @(posedge clk); #1;
    start = 1'b0; opa = $urandom; opb = $urandom; signed_div = 1'($urandom);
    #1;
    lat = 1;
    while (!ready && lat < 60) begin
      if (stall) stalls++;
      if (hilo_we) early_we++;
      @(posedge clk); #2;
      lat++;
    end
    check_eq({tag, ".latency"}, W'(lat), (b == 0) ? W'(1) : W'(W + 1));
    check_eq({tag, ".stall_cycles"}, W'(stalls), (b == 0) ? W'(1) : W'(W + 1));
    check_eq({tag, ".early_we"}, W'(early_we), '0);
    check_eq({tag, ".hilo_we"}, W'(hilo_we), W'(1));
    check_eq({tag, ".stall_done"}, W'(stall), '0);
    check_eq({tag, ".dbz"}, W'(div_by_zero), W'(b == 0));
    check_eq({tag, ".lo"}, result_lo, eq);
    check_eq({tag, ".hi"}, result_hi, er);
    last_lo = eq;
    last_hi = er;
    @(posedge clk); #2;
    check_eq({tag, ".ready_after"}, W'(ready), '0);
    check_eq({tag, ".dbz_after"}, W'(div_by_zero), '0);
    check_eq({tag, ".lo_hold"}, result_lo, eq);
  endtask

  initial begin
    int we_seen;
    logic [W-1:0] a;
    logic [W-1:0] b;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;
    check_eq("reset.ready", W'(ready), '0);
    check_eq("reset.hilo_we", W'(hilo_we), '0);
    check_eq("reset.stall", W'(stall), '0);
    check_eq("reset.dbz", W'(div_by_zero), '0);
    check_eq("reset.hi", result_hi, '0);
    check_eq("reset.lo", result_lo, '0);
    @(posedge clk); #1;

    run_op("divu_100_7", 32'd100, 32'd7, 1'b0);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_5_0", 32'd5, 32'd0, 1'b0);
    run_op("div_m9_0", 32'hFFFF_FFF7, 32'd0, 1'b1);
    run_op("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("divu_3_max", 32'd3, 32'hFFFF_FFFF, 1'b0);

    // Annul on the 10th BUSY cycle: no write, results held
    @(posedge clk); #1;
    start = 1'b1; opa = 32'd1000; opb = 32'd3; signed_div = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1; annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0; #1;
    check_eq("annul.stall", W'(stall), '0);
    check_eq("annul.ready", W'(ready), '0);
    we_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (hilo_we || ready) we_seen++;
      @(posedge clk); #2;
    end
    check_eq("annul.no_we", W'(we_seen), '0);
    check_eq("annul.lo_hold", result_lo, last_lo);
    check_eq("annul.hi_hold", result_hi, last_hi);
    #1;
    run_op("after_annul_9_3", 32'd9, 32'd3, 1'b0);

    // Reset on the 5th BUSY cycle
    @(posedge clk); #1;
    start = 1'b1; opa = 32'd50000; opb = 32'd13; signed_div = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check_eq("rst_busy.stall", W'(stall), '0);
    check_eq("rst_busy.ready", W'(ready), '0);
    check_eq("rst_busy.hilo_we", W'(hilo_we), '0);
    check_eq("rst_busy.dbz", W'(div_by_zero), '0);
    check_eq("rst_busy.hi", result_hi, '0);
    check_eq("rst_busy.lo", result_lo, '0);
    @(posedge clk); #1;
    check_eq("rst_busy.idle_ready", W'(ready), '0);
    run_op("after_rst", 32'd50000, 32'd13, 1'b0);

    for (int k = 0; k < 40; k++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      @(posedge clk); #1;
      run_op($sformatf("rand%0d", k), a, b, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
